// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-port ALU arbiter and its execution unit:
//   - datapath widths
//   - ALUOp encodings and the highest legal opcode
//   - arbiter FSM state encoding
//   - op_legal(): true for opcodes the ALU implements
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD       = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 3'd1;
  localparam logic [OP_W-1:0] OP_AND       = 3'd2;
  localparam logic [OP_W-1:0] OP_OR        = 3'd3;
  localparam logic [OP_W-1:0] OP_SRL       = 3'd4;
  localparam logic [OP_W-1:0] OP_SRA       = 3'd5;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU shared by the arbiter's two requesters.
// Ports:
//   A, B   in  DATA_W  operands
//   ALUOp  in  OP_W    operation select (add/sub/and/or/srl/sra)
//   C      out DATA_W  result; 0 for unimplemented opcodes
// Shifts use the full width of B: any amount >= DATA_W shifts everything out
// (zero fill for SRL, sign fill for SRA).
// -----------------------------------------------------------------------------
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   ALUOp,
  output logic [DATA_W-1:0] C
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] w_a_s;
  logic        [SH_W-1:0]   w_sh;
  logic                     w_sh_big;

  assign w_a_s    = A;
  assign w_sh     = B[SH_W-1:0];
  // Any set bit above the low SH_W bits means the shift amount is >= DATA_W.
  assign w_sh_big = |B[DATA_W-1:SH_W];

  always_comb begin
    C = '0;
    case (ALUOp)
      OP_ADD: C = A + B;
      OP_SUB: C = A - B;
      OP_AND: C = A & B;
      OP_OR:  C = A | B;
      OP_SRL: C = w_sh_big ? '0 : (A >> w_sh);
      OP_SRA: C = w_sh_big ? {DATA_W{A[DATA_W-1]}} : $unsigned(w_a_s >>> w_sh);
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters with round-robin arbitration.
// One transaction in flight: IDLE (grant/accept) -> EXEC (compute) -> RESP
// (hold result until the owner takes it).
// Ports (N = 0,1):
//   clk, reset          clock, synchronous active-high reset
//   reqN_valid/ready    request handshake; ready only in IDLE for the grantee
//   reqN_a/b/op         operands and ALUOp, captured on acceptance
//   rspN_valid/ready    response handshake for the owning port
//   rspN_c/err          result and illegal-op flag; held after valid drops
//   busy                high whenever the FSM is not IDLE
// Parameter INIT_PRIO: port that wins a simultaneous request after reset.
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int INIT_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_c,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_c,
  output logic              rsp1_err,
  output logic              busy
);

  localparam logic PRIO_RST = (INIT_PRIO != 0);

  state_t r_state, w_state_nxt;
  logic   r_prio;
  logic   r_owner;

  logic [1:0] w_req_vld;
  logic [1:0] w_rsp_rdy;
  logic       w_gnt_vld;
  logic       w_gnt;
  logic       w_accept;

  logic [DATA_W-1:0] r_a_p0;
  logic [DATA_W-1:0] r_b_p0;
  logic [OP_W-1:0]   r_op_p0;
  logic [DATA_W-1:0] w_alu_c;

  logic [DATA_W-1:0] r_rsp_c_p1 [2];
  logic [1:0]        r_rsp_err_p1;
  logic [1:0]        r_rsp_vld_p1;

  assign w_req_vld = {req1_valid, req0_valid};
  assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

  // Priority port wins if it asks; otherwise the other port (if it asks).
  assign w_gnt_vld = |w_req_vld;
  assign w_gnt     = w_req_vld[r_prio] ? r_prio : ~r_prio;
  assign w_accept  = (r_state == S_IDLE) && w_gnt_vld;

  assign req0_ready = w_accept && !w_gnt;
  assign req1_ready = w_accept &&  w_gnt;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_rdy[r_owner]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: operands captured on acceptance, then feed the ALU in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_p0  <= '0;
      r_b_p0  <= '0;
      r_op_p0 <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_a_p0  <= w_gnt ? req1_a  : req0_a;
      r_b_p0  <= w_gnt ? req1_b  : req0_b;
      r_op_p0 <= w_gnt ? req1_op : req0_op;
      r_owner <= w_gnt;
    end
  end

  alu u_alu (
    .A     (r_a_p0),
    .B     (r_b_p0),
    .ALUOp (r_op_p0),
    .C     (w_alu_c)
  );

  // Stage p1: response registers per port, written at the end of EXEC and
  // held until the owner's handshake; c/err persist after valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_c_p1[0] <= '0;
      r_rsp_c_p1[1] <= '0;
      r_rsp_err_p1  <= '0;
      r_rsp_vld_p1  <= '0;
      r_prio        <= PRIO_RST;
    end else begin
      if (r_state == S_EXEC) begin
        r_rsp_c_p1[r_owner]   <= op_legal(r_op_p0) ? w_alu_c : '0;
        r_rsp_err_p1[r_owner] <= !op_legal(r_op_p0);
        r_rsp_vld_p1[r_owner] <= 1'b1;
      end
      if ((r_state == S_RESP) && w_rsp_rdy[r_owner]) begin
        r_rsp_vld_p1[r_owner] <= 1'b0;
        r_prio                <= ~r_owner;
      end
    end
  end

  assign rsp0_valid = r_rsp_vld_p1[0];
  assign rsp1_valid = r_rsp_vld_p1[1];
  assign rsp0_c     = r_rsp_c_p1[0];
  assign rsp1_c     = r_rsp_c_p1[1];
  assign rsp0_err   = r_rsp_err_p1[0];
  assign rsp1_err   = r_rsp_err_p1[1];

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] req0_a, req0_b, rsp0_c;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] req1_a, req1_b, rsp1_c;
  logic [2:0]  req1_op;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter #(.INIT_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_err(rsp1_err),
    .busy(busy)
  );

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_c;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    logic own_rdy, oth_rdy, own_vld, oth_vld, own_err;
    logic [31:0] own_c;
    @(negedge clk);
    set_req(v.port, 1'b1, v.a, v.b, v.op);
    if (v.port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    #1;
    own_rdy = v.port ? req1_ready : req0_ready;
    oth_rdy = v.port ? req0_ready : req1_ready;
    chk($sformatf("v%0d accept ready", idx), {31'd0, own_rdy}, 32'd1);
    chk($sformatf("v%0d other ready", idx), {31'd0, oth_rdy}, 32'd0);
    chk($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines: the captured operands must be unaffected.
    set_req(v.port, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 3'd7);
    #1;
    own_vld = v.port ? rsp1_valid : rsp0_valid;
    chk($sformatf("v%0d exec busy", idx), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d exec rsp_valid", idx), {31'd0, own_vld}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    own_vld = v.port ? rsp1_valid : rsp0_valid;
    oth_vld = v.port ? rsp0_valid : rsp1_valid;
    own_c   = v.port ? rsp1_c : rsp0_c;
    own_err = v.port ? rsp1_err : rsp0_err;
    chk($sformatf("v%0d rsp_valid", idx), {31'd0, own_vld}, 32'd1);
    chk($sformatf("v%0d other rsp_valid", idx), {31'd0, oth_vld}, 32'd0);
    chk($sformatf("v%0d c", idx), own_c, v.exp_c);
    chk($sformatf("v%0d err", idx), {31'd0, own_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d resp busy", idx), {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    own_vld = v.port ? rsp1_valid : rsp0_valid;
    own_c   = v.port ? rsp1_c : rsp0_c;
    chk($sformatf("v%0d rsp_valid drop", idx), {31'd0, own_vld}, 32'd0);
    chk($sformatf("v%0d c held", idx), own_c, v.exp_c);
    chk($sformatf("v%0d back idle", idx), {31'd0, busy}, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'd5,         32'd3,          3'd0, 32'd8,          1'b0};
    vecs[1] = '{1, 32'h8000_0000, 32'd4,          3'd5, 32'hF800_0000,  1'b0};
    vecs[2] = '{1, 32'h8000_0000, 32'd4,          3'd4, 32'h0800_0000,  1'b0};
    vecs[3] = '{1, 32'h8000_0000, 32'd40,         3'd5, 32'hFFFF_FFFF,  1'b0};
    vecs[4] = '{1, 32'h8000_0000, 32'd40,         3'd4, 32'h0000_0000,  1'b0};
    vecs[5] = '{0, 32'h0000_1234, 32'h0000_5678,  3'd6, 32'h0000_0000,  1'b1};
    vecs[6] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  3'd7, 32'h0000_0000,  1'b1};
    vecs[7] = '{0, 32'h0000_0001, 32'h0000_0002,  3'd3, 32'h0000_0003,  1'b0};
    vecs[8] = '{1, 32'hFFFF_FFFF, 32'h0000_0001,  3'd0, 32'h0000_0000,  1'b0};
    vecs[9] = '{0, 32'h0000_0000, 32'h0000_0001,  3'd1, 32'hFFFF_FFFF,  1'b0};

    reset = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("reset rsp0_c", rsp0_c, 32'd0);
    chk("reset rsp1_err", {31'd0, rsp1_err}, 32'd0);
    chk("reset req0_ready", {31'd0, req0_ready}, 32'd0);

    for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

    // Simultaneous requests with back-pressure on port 0.
    pulse_reset();
    set_req(0, 1'b1, 32'd3, 32'd5, 3'd1);
    set_req(1, 1'b1, 32'hF0F0_0000, 32'h0FF0_FFFF, 3'd2);
    rsp0_ready = 1'b0;
    #1;
    chk("sim ready0", {31'd0, req0_ready}, 32'd1);
    chk("sim ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    #1;
    chk("sim exec ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
      chk($sformatf("bp%0d rsp0_c", i), rsp0_c, 32'hFFFF_FFFE);
      chk($sformatf("bp%0d ready1", i), {31'd0, req1_ready}, 32'd0);
      chk($sformatf("bp%0d rsp1_valid", i), {31'd0, rsp1_valid}, 32'd0);
    end
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("after hs rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("after hs rsp0_c held", rsp0_c, 32'hFFFF_FFFE);
    chk("after hs ready1", {31'd0, req1_ready}, 32'd1);
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("p1 rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("p1 rsp1_c", rsp1_c, 32'h00F0_0000);
    chk("p1 rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk("p1 drop", {31'd0, rsp1_valid}, 32'd0);

    // Serve port 0 so priority moves to port 1, then abort a port 0 request.
    do_txn('{0, 32'd2, 32'd2, 3'd0, 32'd4, 1'b0}, 100);
    @(negedge clk);
    set_req(0, 1'b1, 32'd7, 32'd8, 3'd0);
    rsp0_ready = 1'b1;
    #1;
    chk("abort accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    #1;
    chk("abort in exec", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort rsp0_valid later", {31'd0, rsp0_valid}, 32'd0);
    set_req(0, 1'b1, 32'd10, 32'd20, 3'd0);
    set_req(1, 1'b1, 32'd1, 32'd1, 3'd0);
    #1;
    chk("post-abort prio ready0", {31'd0, req0_ready}, 32'd1);
    chk("post-abort prio ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post-abort rsp0_c", rsp0_c, 32'd30);
    chk("post-abort rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    chk("post-abort ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post-abort rsp1_c", rsp1_c, 32'd2);
    chk("post-abort rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
